// File: rtl/fu_pkg.sv
// Shared types and constants for functional units that retire through a result queue.
// The entry struct reflects the default unit widths (8-bit data, 4-bit ROB tag, 8-bit flags).
package fu_pkg;

    localparam int FLAG_NT_BIT   = 5;
    localparam int FLAG_NOWB_BIT = 7;

    localparam int FU_XLEN    = 8;
    localparam int FU_ROBID_W = 4;
    localparam int FU_FLAGS_W = 8;
    localparam int FU_WBS_W   = 8;

    // Sign class of a single operand; the encoding doubles as the condition-mask index.
    typedef enum logic [1:0] {
        CLS_ZERO     = 2'd0,
        CLS_POS      = 2'd1,
        CLS_MOST_NEG = 2'd2,
        CLS_NEG      = 2'd3
    } cond_class_e;

    typedef enum logic {
        MODE_CLASS = 1'b0,
        MODE_CMP   = 1'b1
    } jump_mode_e;

    typedef struct packed {
        logic [FU_XLEN-1:0]    value;
        logic [FU_WBS_W-1:0]   wbs;
        logic [FU_FLAGS_W-1:0] flags;
        logic [FU_ROBID_W-1:0] robid;
        logic                  cdb_pend;
        logic                  rob_pend;
    } fu_entry_t;

endpackage

// File: rtl/cjump_unit_q_if.sv
// Issue-side and CDB/ROB-side signals of the conditional-jump unit.
// master = issue/arbiter side, slave = the unit itself.
interface cjump_unit_q_if #(
    parameter int XLEN    = 8,
    parameter int ROBID_W = 4,
    parameter int FLAGS_W = 8
);
    logic                 input_transmit;
    logic [7:0]           operand;
    logic [3*XLEN-1:0]    depvals;
    logic [7:0]           wbs;
    logic [FLAGS_W-1:0]   flags;
    logic [ROBID_W-1:0]   robid;
    logic                 flush;
    logic                 cdb_transmit;
    logic                 cdb_transmit_out;
    logic [ROBID_W-1:0]   cdb_id;
    logic [XLEN-1:0]      cdb_val;
    logic                 rob_transmit;
    logic                 rob_transmit_out;
    logic [ROBID_W-1:0]   robid_out;
    logic [FLAGS_W-1:0]   flags_out;
    logic [7:0]           wbs_out;
    logic [XLEN-1:0]      value_out;
    logic                 busy;

    modport master (
        output input_transmit, operand, depvals, wbs, flags, robid, flush,
               cdb_transmit, rob_transmit,
        input  cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out,
               robid_out, flags_out, wbs_out, value_out, busy
    );

    modport slave (
        input  input_transmit, operand, depvals, wbs, flags, robid, flush,
               cdb_transmit, rob_transmit,
        output cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out,
               robid_out, flags_out, wbs_out, value_out, busy
    );
endinterface

// File: rtl/fu_result_queue.sv
// DEPTH-entry result queue whose head drains through independent CDB and ROB handshakes.
// The head pops on the edge where its last pending bit clears.
module fu_result_queue #(
    parameter int PAYLOAD_W = 28,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_cdb_pend,
    input  logic                 i_cdb_accept,
    input  logic                 i_rob_accept,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic                 o_cdb_pend,
    output logic                 o_rob_pend,
    output logic                 o_busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]     r_cdb_pend;
    logic [DEPTH-1:0]     r_rob_pend;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic w_empty, w_full, w_head_cdb, w_head_rob;
    logic w_cdb_clr, w_rob_clr, w_pop, w_push;

    // Explicit wrap keeps non-power-of-2 depths legal.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_head_cdb = !w_empty && r_cdb_pend[r_head];
    assign w_head_rob = !w_empty && r_rob_pend[r_head];
    assign w_cdb_clr  = w_head_cdb && i_cdb_accept;
    assign w_rob_clr  = w_head_rob && i_rob_accept;
    assign w_pop      = (w_cdb_clr || w_rob_clr)
                        && (!w_head_cdb || w_cdb_clr)
                        && (!w_head_rob || w_rob_clr);
    assign w_push     = i_push && !w_full;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_inc(r_tail);
            if (w_pop)  r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Push and head-clear never target the same slot: tail==head only when empty or full.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst || i_flush) begin
                r_cdb_pend[i] <= 1'b0;
                r_rob_pend[i] <= 1'b0;
            end else if (w_push && r_tail == PTR_W'(i)) begin
                r_cdb_pend[i] <= i_cdb_pend;
                r_rob_pend[i] <= 1'b1;
            end else if (r_head == PTR_W'(i)) begin
                if (w_cdb_clr) r_cdb_pend[i] <= 1'b0;
                if (w_rob_clr) r_rob_pend[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_payload;
    end

    assign o_payload  = w_empty ? '0 : r_mem[r_head];
    assign o_cdb_pend = w_head_cdb;
    assign o_rob_pend = w_head_rob;
    assign o_busy     = w_full;

endmodule

// File: rtl/cjump_unit_q.sv
// Conditional-jump functional unit: decides taken/not-taken by operand sign class or
// signed compare, and queues target plus updated flags for the CDB and ROB.
module cjump_unit_q
    import fu_pkg::*;
#(
    parameter int XLEN     = 8,
    parameter int ROBID_W  = 4,
    parameter int FLAGS_W  = 8,
    parameter int DEPTH    = 2,
    parameter int NT_BIT   = FLAG_NT_BIT,
    parameter int NOWB_BIT = FLAG_NOWB_BIT
) (
    input  logic           clk,
    input  logic           rst,
    cjump_unit_q_if.slave  bus
);
    localparam int PAYLOAD_W = XLEN + 8 + FLAGS_W + ROBID_W;

    logic [XLEN-1:0]      w_x, w_a, w_target;
    jump_mode_e           w_mode;
    cond_class_e          w_class;
    logic [1:0]           w_idx;
    logic                 w_taken;
    logic [FLAGS_W-1:0]   w_upd_flags;
    logic [PAYLOAD_W-1:0] w_payload, w_head;
    logic [XLEN-1:0]      w_head_value;
    logic [7:0]           w_head_wbs;
    logic [FLAGS_W-1:0]   w_head_flags;
    logic [ROBID_W-1:0]   w_head_robid;
    logic                 w_cdb_pend_out, w_rob_pend_out, w_busy;

    assign w_x      = bus.depvals[2*XLEN +: XLEN];
    assign w_a      = bus.depvals[XLEN +: XLEN];
    assign w_target = bus.depvals[0 +: XLEN];

    // Compare mode never yields index 3, so mask bit 3 is dead there.
    always_comb begin
        w_mode  = jump_mode_e'(bus.operand[4]);
        w_class = cond_class_e'({w_a[XLEN-1], |w_a[XLEN-2:0]});
        if (w_mode == MODE_CLASS) begin
            w_idx = w_class;
        end else begin
            w_idx = {$signed(w_x) < $signed(w_a), w_x == w_a};
        end
        w_taken             = bus.operand[w_idx];
        w_upd_flags         = bus.flags;
        w_upd_flags[NT_BIT] = ~w_taken;
    end

    assign w_payload = {w_target, bus.wbs, w_upd_flags, bus.robid};

    fu_result_queue #(
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (bus.flush),
        .i_push       (bus.input_transmit),
        .i_payload    (w_payload),
        .i_cdb_pend   (~w_upd_flags[NOWB_BIT]),
        .i_cdb_accept (bus.cdb_transmit),
        .i_rob_accept (bus.rob_transmit),
        .o_payload    (w_head),
        .o_cdb_pend   (w_cdb_pend_out),
        .o_rob_pend   (w_rob_pend_out),
        .o_busy       (w_busy)
    );

    assign {w_head_value, w_head_wbs, w_head_flags, w_head_robid} = w_head;

    assign bus.cdb_transmit_out = w_cdb_pend_out;
    assign bus.rob_transmit_out = w_rob_pend_out;
    assign bus.cdb_id           = w_head_robid;
    assign bus.cdb_val          = w_head_value;
    assign bus.robid_out        = w_head_robid;
    assign bus.flags_out        = w_head_flags;
    assign bus.wbs_out          = w_head_wbs;
    assign bus.value_out        = w_head_value;
    assign bus.busy             = w_busy;

endmodule

// File: tb/tb_cjump_unit_q.sv
// Directed bench for cjump_unit_q: a scoreboard queue models the result queue and is
// compared against the head outputs after every clock edge.
module tb_cjump_unit_q;
    import fu_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cjump_unit_q_if #(.XLEN(8), .ROBID_W(4), .FLAGS_W(8)) bus ();

    cjump_unit_q #(
        .XLEN(8), .ROBID_W(4), .FLAGS_W(8), .DEPTH(DEPTH), .NT_BIT(5), .NOWB_BIT(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fu_entry_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decision written as explicit class/compare cases.
    function automatic fu_entry_t model_entry();
        fu_entry_t e;
        logic [7:0] x, a;
        int cls;
        x = bus.depvals[23:16];
        a = bus.depvals[15:8];
        if (bus.operand[4] == 1'b0) begin
            if (a == 8'h00)      cls = 0;
            else if (a == 8'h80) cls = 2;
            else if (a[7])       cls = 3;
            else                 cls = 1;
        end else begin
            if ($signed(x) > $signed(a)) cls = 0;
            else if (x == a)             cls = 1;
            else                         cls = 2;
        end
        e.value    = bus.depvals[7:0];
        e.wbs      = bus.wbs;
        e.flags    = bus.flags;
        e.flags[5] = ~bus.operand[cls];
        e.robid    = bus.robid;
        e.cdb_pend = ~e.flags[7];
        e.rob_pend = 1'b1;
        return e;
    endfunction

    task automatic set_op(input bit mode, input logic [3:0] mask, input logic [7:0] x,
                          input logic [7:0] a, input logic [7:0] tgt, input logic [7:0] fl,
                          input logic [3:0] id, input logic [7:0] wb);
        bus.input_transmit = 1'b1;
        bus.operand        = {3'b101, mode, mask};
        bus.depvals        = {x, a, tgt};
        bus.flags          = fl;
        bus.robid          = id;
        bus.wbs            = wb;
    endtask

    // Apply the driven inputs to the model, clock once, then release the strobes.
    task automatic step();
        fu_entry_t e;
        bit was_full;
        was_full = (sb.size() == DEPTH);
        if (bus.flush) begin
            sb.delete();
        end else begin
            if (sb.size() > 0) begin
                e = sb[0];
                if (bus.cdb_transmit) e.cdb_pend = 1'b0;
                if (bus.rob_transmit) e.rob_pend = 1'b0;
                sb[0] = e;
                if (!e.cdb_pend && !e.rob_pend) void'(sb.pop_front());
            end
            if (bus.input_transmit && !was_full) sb.push_back(model_entry());
        end
        @(posedge clk);
        #1;
        bus.input_transmit = 1'b0;
        bus.cdb_transmit   = 1'b0;
        bus.rob_transmit   = 1'b0;
        bus.flush          = 1'b0;
    endtask

    task automatic check_head(input string tag);
        fu_entry_t e;
        e = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, "_cdb_out"}, bus.cdb_transmit_out, e.cdb_pend);
        chk({tag, "_rob_out"}, bus.rob_transmit_out, e.rob_pend);
        chk({tag, "_cdb_id"},  bus.cdb_id,    e.robid);
        chk({tag, "_cdb_val"}, bus.cdb_val,   e.value);
        chk({tag, "_robid"},   bus.robid_out, e.robid);
        chk({tag, "_flags"},   bus.flags_out, e.flags);
        chk({tag, "_wbs"},     bus.wbs_out,   e.wbs);
        chk({tag, "_value"},   bus.value_out, e.value);
        chk({tag, "_busy"},    bus.busy,      (sb.size() == DEPTH));
        $display("step %s: depth=%0d head_robid=%0h val=%0h flags=%0h cdb=%0b rob=%0b busy=%0b",
                 tag, sb.size(), bus.robid_out, bus.value_out, bus.flags_out,
                 bus.cdb_transmit_out, bus.rob_transmit_out, bus.busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    bit         w_mode [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] w_mask [5] = '{4'b0100, 4'b1000, 4'b0010, 4'b0010, 4'b1000};
    logic [7:0] w_xv   [5] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
    logic [7:0] w_av   [5] = '{8'h80, 8'h90, 8'h05, 8'h01, 8'hFE};

    initial begin
        bus.input_transmit = 1'b0;
        bus.operand        = '0;
        bus.depvals        = '0;
        bus.wbs            = '0;
        bus.flags          = '0;
        bus.robid          = '0;
        bus.flush          = 1'b0;
        bus.cdb_transmit   = 1'b0;
        bus.rob_transmit   = 1'b0;
        do_reset();
        check_head("reset");

        // Zero operand in class mode, mask selects zero -> taken.
        set_op(1'b0, 4'b0001, 8'h00, 8'h00, 8'h40, 8'h00, 4'h1, 8'h11);
        step();
        check_head("t1");
        chk("t1_nt_bit", bus.flags_out[5], 1'b0);
        bus.cdb_transmit = 1'b1; bus.rob_transmit = 1'b1;
        step();
        check_head("t1_pop");

        // Signed compare: -1 < 1.
        set_op(1'b1, 4'b0100, 8'hFF, 8'h01, 8'h22, 8'h00, 4'h2, 8'h02);
        step();
        check_head("t2_lt");
        chk("t2_lt_nt_bit", bus.flags_out[5], 1'b0);
        set_op(1'b1, 4'b0001, 8'hFF, 8'h01, 8'h23, 8'h00, 4'h3, 8'h03);
        step();
        check_head("t2_two");
        bus.cdb_transmit = 1'b1; bus.rob_transmit = 1'b1;
        step();
        check_head("t2_gt");
        chk("t2_gt_nt_bit", bus.flags_out[5], 1'b1);
        bus.cdb_transmit = 1'b1; bus.rob_transmit = 1'b1;
        step();
        check_head("t2_empty");

        // No-writeback entry: CDB accept is ignored, ROB accept pops.
        set_op(1'b0, 4'b0010, 8'h00, 8'h05, 8'h77, 8'h80, 4'h4, 8'h44);
        step();
        check_head("t3");
        bus.cdb_transmit = 1'b1;
        step();
        check_head("t3_cdb_ign");
        bus.rob_transmit = 1'b1;
        step();
        check_head("t3_pop");

        // Three back-to-back pushes into a two-entry queue.
        set_op(1'b0, 4'b0010, 8'h00, 8'h33, 8'h51, 8'h00, 4'h5, 8'h05);
        step();
        check_head("t4_p1");
        set_op(1'b0, 4'b0010, 8'h00, 8'h34, 8'h52, 8'h00, 4'h6, 8'h06);
        step();
        check_head("t4_p2");
        set_op(1'b0, 4'b0010, 8'h00, 8'h35, 8'h53, 8'h00, 4'h7, 8'h07);
        step();
        check_head("t4_p3");
        bus.cdb_transmit = 1'b1;
        step();
        check_head("t4_cdb_k");
        step();
        check_head("t4_idle");
        bus.rob_transmit = 1'b1;
        step();
        check_head("t4_rob_k2");
        chk("t4_second_head", bus.robid_out, 4'h6);

        // Full queue: simultaneous push and pop refuses the push.
        set_op(1'b1, 4'b0001, 8'h10, 8'h01, 8'h61, 8'h00, 4'h8, 8'h08);
        step();
        check_head("t5_full");
        set_op(1'b1, 4'b0001, 8'h10, 8'h01, 8'h62, 8'h00, 4'h9, 8'h09);
        bus.cdb_transmit = 1'b1; bus.rob_transmit = 1'b1;
        step();
        check_head("t5_refuse");
        chk("t5_head_8", bus.robid_out, 4'h8);

        // Pointer wrap: push/pop pairs keep FIFO order.
        for (int i = 0; i < 5; i++) begin
            set_op(w_mode[i], w_mask[i], w_xv[i], w_av[i], 8'h70 + 8'(i),
                   8'(i * 8'h21), 4'(10 + i), 8'(i));
            bus.cdb_transmit = 1'b1; bus.rob_transmit = 1'b1;
            step();
            check_head($sformatf("t5_wrap%0d", i));
        end

        // Flush with a full queue and a concurrent push.
        set_op(1'b0, 4'b0001, 8'h00, 8'h00, 8'h81, 8'h00, 4'h1, 8'h21);
        step();
        check_head("t6_fill");
        set_op(1'b0, 4'b0001, 8'h00, 8'h00, 8'h82, 8'h00, 4'h2, 8'h22);
        bus.flush = 1'b1;
        step();
        check_head("t6_flush");

        // Reset in the middle of a drain.
        set_op(1'b0, 4'b0001, 8'h00, 8'h00, 8'h91, 8'h00, 4'h3, 8'h31);
        step();
        set_op(1'b0, 4'b0001, 8'h00, 8'h00, 8'h92, 8'h00, 4'h4, 8'h32);
        step();
        bus.cdb_transmit = 1'b1;
        step();
        check_head("t6_pre_rst");
        do_reset();
        check_head("t6_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
